// File: rtl/map_pkg.sv
// Shared definitions for the max-log-MAP decoder: trellis of the 4-state RSC code
// (feedback 1+D+D^2, feedforward 1+D^2), metric floor and FSM state encoding.
package map_pkg;

   localparam int NUM_STATES = 4;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } fsm_state_t;

   // Lowest metric a normalized alpha may take; also the "unreachable" start value.
   function automatic int neg_metric(input int w);
      return -(1 << (w - 2));
   endfunction

   function automatic logic [1:0] trellis_next(input logic [1:0] s, input logic u);
      logic a;
      a = u ^ s[1] ^ s[0];
      return {a, s[1]};
   endfunction

   function automatic logic trellis_parity(input logic [1:0] s, input logic u);
      logic a;
      a = u ^ s[1] ^ s[0];
      return a ^ s[0];
   endfunction

endpackage

// File: rtl/acs_unit.sv
// Add-compare-select for one next state. Branch 0 must be the u=0 branch so that
// a tie resolves towards it.
module acs_unit #(
   parameter int W = 12
) (
   input  logic signed [W-1:0] alpha0,
   input  logic signed [W-1:0] gamma0,
   input  logic signed [W-1:0] alpha1,
   input  logic signed [W-1:0] gamma1,
   output logic signed [W-1:0] metric
);

   logic signed [W-1:0] sum0;
   logic signed [W-1:0] sum1;

   always_comb begin
      sum0   = alpha0 + gamma0;
      sum1   = alpha1 + gamma1;
      metric = (sum1 > sum0) ? sum1 : sum0;
   end

endmodule

// File: rtl/alpha_recursion.sv
// Forward (alpha) recursion stage of the max-log-MAP decoder. Define ALPHA_STORE_EN
// to add the per-step alpha memory and its rd_addr/rd_data read port.
module alpha_recursion
   import map_pkg::*;
#(
   parameter int FRAME_LEN = 16,
   parameter int W_IN      = 6,
   parameter int W_M       = 10
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           start,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic signed [W_IN-1:0]         llr_sys,
   input  logic signed [W_IN-1:0]         llr_par,
   output logic                           alpha_valid,
   output logic [NUM_STATES*W_M-1:0]      alpha_out,
   output logic [$clog2(FRAME_LEN)-1:0]   step_idx,
   output logic                           busy,
   output logic                           done_fwd
`ifdef ALPHA_STORE_EN
   ,
   input  logic [$clog2(FRAME_LEN)-1:0]   rd_addr,
   output logic [NUM_STATES*W_M-1:0]      rd_data
`endif
);

   localparam int IW = $clog2(FRAME_LEN);
   // Two guard bits: one for metric+branch growth, one for the normalization difference.
   localparam int WX = W_M + 2;
   localparam logic signed [W_M-1:0] NEG_M = W_M'(neg_metric(W_M));
   localparam logic signed [WX-1:0]  NEG_X = WX'(neg_metric(W_M));
   localparam logic signed [WX-1:0]  MAX_X = WX'((1 << (W_M - 1)) - 1);

   fsm_state_t state, state_next;
   logic accept;
   logic last_step;
   logic [IW-1:0] count;

   logic signed [W_M-1:0] alpha_q   [NUM_STATES];
   logic signed [W_M-1:0] alpha_new [NUM_STATES];
   logic signed [WX-1:0]  sys_x, par_x, br_gamma, norm_diff;
   logic [1:0]            br_ns;
   logic                  br_par;
   logic signed [WX-1:0]  cand_alpha [NUM_STATES][2];
   logic signed [WX-1:0]  cand_gamma [NUM_STATES][2];
   logic signed [WX-1:0]  acs_metric [NUM_STATES];

   assign accept    = in_valid & in_ready;
   assign last_step = (count == IW'(FRAME_LEN - 1));

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      busy       = 1'b0;
      done_fwd   = 1'b0;
      case (state)
         IDLE: if (start) state_next = RUN;
         RUN: begin
            in_ready = 1'b1;
            busy     = 1'b1;
            if (in_valid && last_step) state_next = DONE;
         end
         DONE: begin
            busy       = 1'b1;
            done_fwd   = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Route every (state, input) branch to its next state, slot indexed by u.
   always_comb begin
      sys_x    = WX'(llr_sys);
      par_x    = WX'(llr_par);
      br_ns    = '0;
      br_par   = 1'b0;
      br_gamma = '0;
      for (int n = 0; n < NUM_STATES; n++) begin
         for (int u = 0; u < 2; u++) begin
            cand_alpha[n][u] = '0;
            cand_gamma[n][u] = '0;
         end
      end
      for (int s = 0; s < NUM_STATES; s++) begin
         for (int u = 0; u < 2; u++) begin
            br_ns    = trellis_next(2'(s), 1'(u));
            br_par   = trellis_parity(2'(s), 1'(u));
            br_gamma = ((u != 0) ? sys_x : -sys_x) + (br_par ? par_x : -par_x);
            cand_alpha[br_ns][u] = WX'(alpha_q[s]);
            cand_gamma[br_ns][u] = br_gamma;
         end
      end
   end

   for (genvar g = 0; g < NUM_STATES; g++) begin : g_acs
      acs_unit #(.W(WX)) u_acs (
         .alpha0 (cand_alpha[g][0]),
         .gamma0 (cand_gamma[g][0]),
         .alpha1 (cand_alpha[g][1]),
         .gamma1 (cand_gamma[g][1]),
         .metric (acs_metric[g])
      );
   end

   always_comb begin
      norm_diff = '0;
      for (int k = 0; k < NUM_STATES; k++) begin
         norm_diff = acs_metric[k] - acs_metric[0];
         if (norm_diff > MAX_X)      alpha_new[k] = W_M'(MAX_X);
         else if (norm_diff < NEG_X) alpha_new[k] = NEG_M;
         else                        alpha_new[k] = W_M'(norm_diff);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < NUM_STATES; k++) alpha_q[k] <= (k == 0) ? '0 : NEG_M;
         alpha_out   <= '0;
         alpha_valid <= 1'b0;
         step_idx    <= '0;
         count       <= '0;
      end else begin
         alpha_valid <= 1'b0;
         if (state == IDLE && start) begin
            for (int k = 0; k < NUM_STATES; k++) alpha_q[k] <= (k == 0) ? '0 : NEG_M;
            step_idx <= '0;
            count    <= '0;
         end else if (accept) begin
            for (int k = 0; k < NUM_STATES; k++) begin
               alpha_q[k]               <= alpha_new[k];
               alpha_out[k*W_M +: W_M] <= alpha_new[k];
            end
            alpha_valid <= 1'b1;
            step_idx    <= count;
            count       <= count + IW'(1);
         end
      end
   end

`ifdef ALPHA_STORE_EN
   logic [NUM_STATES*W_M-1:0] mem [FRAME_LEN];

   always_ff @(posedge clk) begin
      if (alpha_valid) mem[step_idx] <= alpha_out;
   end

   // Registered read; a colliding write lands after the read, so old data is returned.
   always_ff @(posedge clk) begin
      if (rst) rd_data <= '0;
      else     rd_data <= mem[rd_addr];
   end
`endif

endmodule
